// File: rtl/out_uart_tx.sv
// OUT-port serializer: a small word FIFO feeding a UART transmitter, two bytes per word, low first.
// Define UART_PARITY_EN to append an even-parity bit to every byte (8E1 instead of 8N1).
module out_uart_tx #(
    parameter int unsigned CLK_DIV = 174,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   tx
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLK_DIV);
    localparam logic [BaudW-1:0] BaudReload = BaudW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]  CntFull    = CntW'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic [15:0]      mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             byte_sel_q, byte_sel_d;
    logic [15:0]      shift_q, shift_d;

    logic             push, pop;
    logic             baud_tick;
    logic [7:0]       cur_byte;

    assign full      = (count_q == CntFull);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != StIdle) || !empty;
    assign baud_tick = (baud_q == '0);
    assign cur_byte  = byte_sel_q ? shift_q[15:8] : shift_q[7:0];

    // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
    assign push = wr_en && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wr_en & ~push);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        tx         = 1'b1;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    byte_sel_d = 1'b0;
                    baud_d     = BaudReload;
                    state_d    = StStart;
                end
            end
            StStart: begin
                tx = 1'b0;
                if (baud_tick) begin
                    baud_d    = BaudReload;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            StData: begin
                tx = cur_byte[bit_idx_q];
                if (baud_tick) begin
                    baud_d = BaudReload;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                tx = ^cur_byte;
                if (baud_tick) begin
                    baud_d  = BaudReload;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
`endif
            StStop: begin
                tx = 1'b1;
                if (baud_tick) begin
                    if (!byte_sel_q) begin
                        // High byte follows immediately, no idle gap inside a word.
                        byte_sel_d = 1'b1;
                        baud_d     = BaudReload;
                        state_d    = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_sel_q <= 1'b0;
            shift_q    <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: timing-level reference model of FIFO/line plus a UART-decoding monitor.
// Honours UART_PARITY_EN the same way as the design.
module tb_out_uart_tx;
    localparam int unsigned ClkDiv = 4;
    localparam int unsigned Depth  = 4;
`ifdef UART_PARITY_EN
    localparam int Par = 1;
`else
    localparam int Par = 0;
`endif
    localparam longint FrameCyc = (10 + Par) * ClkDiv;
    localparam longint WordCyc  = 2 * FrameCyc;
    localparam longint Spacing  = WordCyc + 1;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        busy;
    logic        tx;

    out_uart_tx #(
        .CLK_DIV (ClkDiv),
        .DEPTH   (Depth)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: accepted words with their write edge, pop edge of the word on the line.
    longint      edge_no  = 0;
    longint      last_pop = -100000;
    longint      pend_t[$];
    logic [15:0] pend_d[$];
    logic [15:0] cur_word = 16'h0000;
    bit          m_ovf    = 1'b0;
    logic [7:0]  exp_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (edge %0d): got %0h, expected %0h", nm, edge_no, act, exp);
        end
    endtask

    task automatic model_reset();
        pend_t.delete();
        pend_d.delete();
        exp_q.delete();
        last_pop = -100000;
        m_ovf    = 1'b0;
    endtask

    function automatic longint next_pop();
        longint t;
        t = pend_t[0] + 1;
        if (last_pop + Spacing > t) t = last_pop + Spacing;
        return t;
    endfunction

    // Advance the model across the coming clock edge.
    task automatic model_step(input bit we, input logic [15:0] d);
        longint e;
        bit     pop;
        bit     acc;
        e   = edge_no + 1;
        pop = (pend_t.size() > 0) && (next_pop() == e);
        acc = we && ((pend_t.size() < Depth) || pop);
        if (pop) begin
            last_pop = e;
            cur_word = pend_d.pop_front();
            void'(pend_t.pop_front());
        end
        if (acc) begin
            pend_t.push_back(e);
            pend_d.push_back(d);
            exp_q.push_back(d[7:0]);
            exp_q.push_back(d[15:8]);
        end else if (we) begin
            m_ovf = 1'b1;
        end
    endtask

    function automatic bit exp_tx();
        longint     o;
        int         pos;
        logic [7:0] b;
        o = edge_no - last_pop;
        if (o < 0 || o >= WordCyc) return 1'b1;
        b   = (o < FrameCyc) ? cur_word[7:0] : cur_word[15:8];
        pos = int'((o % FrameCyc) / ClkDiv);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (Par == 1 && pos == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic check_status();
        chk("count", longint'(count), longint'(pend_t.size()));
        chk("full", longint'(full), longint'(pend_t.size() == Depth));
        chk("empty", longint'(empty), longint'(pend_t.size() == 0));
        chk("overflow", longint'(overflow), longint'(m_ovf));
        chk("busy", longint'(busy),
            longint'(pend_t.size() > 0 || (edge_no - last_pop) < WordCyc));
        chk("tx", longint'(tx), longint'(exp_tx()));
    endtask

    task automatic tick(input bit we, input logic [15:0] d);
        @(negedge clk);
        wr_en   = we;
        wr_data = d;
        model_step(we, d);
        @(posedge clk);
        edge_no++;
        #1;
        check_status();
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_status();
        repeat (2) begin
            @(posedge clk);
            edge_no++;
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        edge_no++;
        #1 check_status();
    endtask

    task automatic drain();
        int guard = 0;
        while ((pend_t.size() > 0 || (edge_no - last_pop) <= WordCyc) && guard < 2000) begin
            tick(1'b0, 16'h0000);
            guard++;
        end
        repeat (3) tick(1'b0, 16'h0000);
    endtask

    task automatic mwait(input int n, output bit hit);
        hit = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) hit = 1'b1;
        end
    endtask

    // Monitor: decode frames from the line and compare with the scoreboard queue.
    initial begin : monitor
        bit          ab;
        bit          hit;
        logic [10:0] bits;
        logic [7:0]  eb;
        int          nb;
        nb = 10 + Par;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                ab   = 1'b0;
                bits = '0;
                for (int k = 0; k < nb && !ab; k++) begin
                    mwait((k == 0) ? int'(ClkDiv / 2) : int'(ClkDiv), hit);
                    ab      = ab | hit;
                    bits[k] = tx;
                end
                if (!ab) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mon_byte: got %0h, expected no byte", bits[8:1]);
                    end else begin
                        eb = exp_q.pop_front();
                        chk("mon_start", longint'(bits[0]), 0);
                        chk("mon_byte", longint'(bits[8:1]), longint'(eb));
                        if (Par == 1) chk("mon_parity", longint'(bits[9]), longint'(^eb));
                        chk("mon_stop", longint'(bits[nb-1]), 1);
                    end
                end
            end
        end
    end

    initial begin : stim
        int guard;
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        #1 rst_n = 1'b0;
        do_reset();

        // Single word: start bit one cycle after the write, idle after one word time.
        tick(1'b1, 16'h12A5);
        tick(1'b0, 16'h0000);
        chk("single_start", longint'(tx), 0);
        repeat (WordCyc) tick(1'b0, 16'h0000);
        chk("single_busy_end", longint'(busy), 0);
        drain();

        // Fill and overflow.
        repeat (5) tick(1'b1, 16'($urandom));
        chk("fill_count", longint'(count), 4);
        tick(1'b1, 16'hDEAD);
        chk("ovf_full", longint'(full), 1);
        chk("ovf_flag", longint'(overflow), 1);
        drain();
        chk("ovf_sticky", longint'(overflow), 1);
        do_reset();

        // Push while full on the pop cycle.
        repeat (5) tick(1'b1, 16'($urandom));
        chk("pf_full", longint'(full), 1);
        guard = 0;
        while (next_pop() != edge_no + 1 && guard < 500) begin
            tick(1'b0, 16'h0000);
            guard++;
        end
        tick(1'b1, 16'hBEEF);
        chk("pf_count", longint'(count), 4);
        chk("pf_overflow", longint'(overflow), 0);
        drain();

        // Pointer wrap-around: stream 1..10, holding off while full.
        for (int i = 1; i <= 10; i++) begin
            guard = 0;
            while (pend_t.size() >= Depth && guard < 500) begin
                tick(1'b0, 16'h0000);
                guard++;
            end
            tick(1'b1, 16'(i));
        end
        drain();

        tick(1'b1, 16'h0703);
        drain();

        // Random traffic, including occasional overflow.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 29) == 0), 16'($urandom));
        end
        drain();

        // Reset during data bit 3 of the low byte.
        tick(1'b1, 16'h5A3C);
        repeat (17) tick(1'b0, 16'h0000);
        do_reset();
        chk("midrst_tx", longint'(tx), 1);
        repeat (3) tick(1'b0, 16'h0000);
        tick(1'b1, 16'h00FF);
        drain();

        chk("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/out_uart_tx.md
# out_uart_tx

Output-port serializer for the SIMPLE processor. It captures the 16-bit value presented by the OUT instruction, buffers it in a small FIFO and transmits each word over an 8N1 UART line as two bytes, low byte first. It sits directly downstream of the processor top: the write strobe comes from the controller's Output signal qualified by the write-back phase, and the data comes from the AR operand register. It runs on the 20 MHz board clock.

## Interface
Parameters:
- CLK_DIV, 174: clk cycles per UART bit (20 MHz / 115200 baud); legal range ≥ 2.
- DEPTH, 4: FIFO depth in words; power of two, ≥ 2.

Ports:
- clk  input  1  board clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  one-cycle write strobe (OUT instruction).
- wr_data  input  16  word to transmit.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds no words.
- count  output  $clog2(DEPTH)+1  words currently held.
- overflow  output  1  sticky: a write was dropped.
- busy  output  1  a frame is in progress or the FIFO is not empty.
- tx  output  1  UART line; idle high.

## Operation
- FIFO: a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a separate count.
- Write rule: the write is accepted if wr_en is high and either count<DEPTH or a pop happens in the same cycle. If wr_en is high while full with no pop, the word is discarded and overflow is set to 1. Only reset clears overflow.
- A simultaneous push and pop leaves count unchanged. When the FIFO is empty, the word written in a cycle is not popped in that same cycle.
- FSM states:
  - IDLE: tx=1. If !empty, pop the head into a 16-bit shift word, clear byte_sel, and go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx=current byte[bit_idx], LSB first, CLK_DIV cycles per bit. After bit 7, go to PARITY (if enabled) or STOP.
  - PARITY: tx = even parity of the current byte, for CLK_DIV cycles, then go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. If byte_sel=0, set byte_sel=1 and go to START, sending wr_data[15:8]. Otherwise go to IDLE.
- Current byte is shift_word[7:0] when byte_sel=0 and shift_word[15:8] when byte_sel=1.
- Baud counter: reloads to CLK_DIV-1 on every state entry and decrements each cycle. The state or bit advances when the counter is 0.
- busy = (state≠IDLE) | !empty.

## Timing
- Reset values: tx=1, full=0, empty=1, count=0, overflow=0, busy=0; pointers 0; state IDLE. Reset takes effect immediately, even mid-frame; the partial frame is abandoned and the FIFO contents are lost.
- Latency: a word written at edge N into an empty FIFO while IDLE is popped at edge N+1, and tx falls at edge N+1.
- Bit period is exactly CLK_DIV cycles.
- Byte frame is 10×CLK_DIV cycles, or 11×CLK_DIV with parity. A word is two frames back to back, with no idle gap between them.
- Consecutive FIFO words: the STOP bit of the high byte is followed by 1 cycle of IDLE (tx=1), then the next START.
- full, empty and count update at the same edge as the push or pop that changes them.

## Configuration
- UART_PARITY_EN defined: the PARITY state is compiled in and adds one even-parity bit after bit 7 (8E1). A word then takes 22×CLK_DIV cycles.
- UART_PARITY_EN undefined: the PARITY state and its logic are absent; the format is 8N1 and a word takes 20×CLK_DIV cycles.

## Test plan
All scenarios use CLK_DIV=4 and DEPTH=4.
- Single word: reset, then write 0x12A5. The line must show: tx low 1 cycle after the write; bits of 0xA5 LSB first; stop; start; bits of 0x12; stop. Total 80 cycles (88 with parity), then busy=0.
- Fill and overflow: 5 writes on consecutive cycles while the line is idle. The first is popped immediately, so all 5 are accepted and count=4. A 6th write gives full=1, overflow=1, and that word is never transmitted.
- Push while full with a pop: with full=1, write on the cycle the FSM pops in IDLE. The write is accepted, count stays 4, and overflow stays 0.
- Pointer wrap-around: stream 10 words 0x0001..0x000A, pausing writes whenever full. All 10 must be received in order with correct byte order.
- Reset mid-frame: assert rst_n=0 during DATA bit 3. tx=1, count=0 and busy=0 must appear immediately. After release, a new write of 0x00FF transmits cleanly.
- Parity (build with UART_PARITY_EN): write 0x0703. The parity bit is 0 for 0x03 and 1 for 0x07.
